// File: rtl/serial_bit_source_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_bit_source_if
//  Description : Bundle for the serial_bit_source block. It carries the word
//                load handshake, the shift-enable stall input and the serial
//                stream outputs.
//                  master : drives load_valid, data_in and shift_en; observes
//                           load_ready, ser_out, ser_valid, done and bit_idx.
//                  slave  : the serializer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_bit_source_if #(
    parameter int WIDTH = 8
) ();
    localparam int c_IDX_W = $clog2(WIDTH);

    logic                  load_valid;
    logic [WIDTH-1:0]      data_in;
    logic                  load_ready;
    logic                  shift_en;
    logic                  ser_out;
    logic                  ser_valid;
    logic                  done;
    logic [c_IDX_W-1:0]    bit_idx;

    modport master (
        output load_valid,
        output data_in,
        output shift_en,
        input  load_ready,
        input  ser_out,
        input  ser_valid,
        input  done,
        input  bit_idx
    );

    modport slave (
        input  load_valid,
        input  data_in,
        input  shift_en,
        output load_ready,
        output ser_out,
        output ser_valid,
        output done,
        output bit_idx
    );
endinterface
`default_nettype wire

// File: rtl/serial_bit_source.sv
`default_nettype none
// ============================================================================
//  Module      : serial_bit_source
//  Description : Parallel-in / serial-out bit source. A WIDTH-bit word is
//                accepted over a valid/ready handshake and presented one bit
//                per clock on ser_out, qualified by ser_valid. Back-to-back
//                words stream with no gap; shift_en = 0 stalls the stream.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - serial_bit_source_if.slave (load handshake,
//                         shift_en, ser_out/ser_valid/done/bit_idx)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_bit_source #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    serial_bit_source_if.slave      bus
);

    localparam int c_IDX_W = $clog2(WIDTH);
    // bit_idx value that is about to become the last one; reaching it on a
    // shift means the new bit is the final bit of the word.
    localparam logic [c_IDX_W-1:0] c_PENULT_IDX = c_IDX_W'(WIDTH - 2);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE    = c_IDX_W'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [WIDTH-1:0]     r_shreg;
    logic                 r_ser_out;
    logic                 r_ser_valid;
    logic                 r_done;
    logic [c_IDX_W-1:0]   r_bit_idx;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     w_shreg_nxt;
    logic                 w_ser_out_nxt;
    logic                 w_ser_valid_nxt;
    logic                 w_done_nxt;
    logic [c_IDX_W-1:0]   w_bit_idx_nxt;

    logic                 w_load_ready;
    logic                 w_accept;
    logic                 w_load_bit;    // first bit of the incoming word
    logic [WIDTH-1:0]     w_shifted;     // shift register after one advance
    logic                 w_next_bit;    // bit presented after one advance

    // Ready depends only on registered state and shift_en, never on
    // load_valid, so there is no combinational loop through the handshake.
    assign w_load_ready = (r_state == IDLE) ||
                          ((r_state == SHIFT) && r_done && bus.shift_en);
    assign w_accept     = bus.load_valid && w_load_ready;

    // ------------------------------------------------------------------
    // Bit-order selection. The shift register always holds the word with
    // the currently presented bit at the output end.
    // ------------------------------------------------------------------
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_load_bit = bus.data_in[WIDTH-1];
            assign w_shifted  = {r_shreg[WIDTH-2:0], 1'b0};
            assign w_next_bit = r_shreg[WIDTH-2];
        end else begin : g_lsb_first
            assign w_load_bit = bus.data_in[0];
            assign w_shifted  = {1'b0, r_shreg[WIDTH-1:1]};
            assign w_next_bit = r_shreg[1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State / datapath register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_done      <= 1'b0;
            r_bit_idx   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_ser_out   <= w_ser_out_nxt;
            r_ser_valid <= w_ser_valid_nxt;
            r_done      <= w_done_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        // Hold everything unless a branch below says otherwise; this is
        // exactly the stall behaviour in SHIFT with shift_en = 0.
        w_state_nxt     = r_state;
        w_shreg_nxt     = r_shreg;
        w_ser_out_nxt   = r_ser_out;
        w_ser_valid_nxt = r_ser_valid;
        w_done_nxt      = r_done;
        w_bit_idx_nxt   = r_bit_idx;

        case (r_state)
            IDLE: begin
                w_ser_out_nxt   = 1'b0;
                w_ser_valid_nxt = 1'b0;
                w_done_nxt      = 1'b0;
                w_bit_idx_nxt   = '0;
                if (w_accept) begin
                    w_shreg_nxt     = bus.data_in;
                    w_ser_out_nxt   = w_load_bit;
                    w_ser_valid_nxt = 1'b1;
                    w_state_nxt     = SHIFT;
                end
            end

            SHIFT: begin
                if (bus.shift_en) begin
                    if (r_done) begin
                        if (w_accept) begin
                            // Chain straight into the next word: no gap.
                            w_shreg_nxt     = bus.data_in;
                            w_ser_out_nxt   = w_load_bit;
                            w_ser_valid_nxt = 1'b1;
                            w_done_nxt      = 1'b0;
                            w_bit_idx_nxt   = '0;
                        end else begin
                            w_state_nxt     = IDLE;
                            w_shreg_nxt     = '0;
                            w_ser_out_nxt   = 1'b0;
                            w_ser_valid_nxt = 1'b0;
                            w_done_nxt      = 1'b0;
                            w_bit_idx_nxt   = '0;
                        end
                    end else begin
                        w_shreg_nxt   = w_shifted;
                        w_ser_out_nxt = w_next_bit;
                        w_bit_idx_nxt = r_bit_idx + c_IDX_ONE;
                        w_done_nxt    = (r_bit_idx == c_PENULT_IDX);
                    end
                end
            end

            default: begin
                w_state_nxt     = IDLE;
                w_shreg_nxt     = '0;
                w_ser_out_nxt   = 1'b0;
                w_ser_valid_nxt = 1'b0;
                w_done_nxt      = 1'b0;
                w_bit_idx_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.load_ready = w_load_ready;
    assign bus.ser_out    = r_ser_out;
    assign bus.ser_valid  = r_ser_valid;
    assign bus.done       = r_done;
    assign bus.bit_idx    = r_bit_idx;

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_source.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_bit_source
//  Description : Directed bench for serial_bit_source. Two instances share
//                clk/rst_n: u_msb (MSB first) and u_lsb (LSB first).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_bit_source;

    localparam int c_WIDTH = 8;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_pass;

    serial_bit_source_if #(.WIDTH(c_WIDTH)) if_msb ();
    serial_bit_source_if #(.WIDTH(c_WIDTH)) if_lsb ();

    serial_bit_source #(.WIDTH(c_WIDTH), .MSB_FIRST(1'b1)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_msb.slave)
    );

    serial_bit_source #(.WIDTH(c_WIDTH), .MSB_FIRST(1'b0)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_lsb.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish before 200000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-written expected streams.
    bit exp_b4_msb [8] = '{1,0,1,1,0,1,0,0};
    bit exp_b4_lsb [8] = '{0,0,1,0,1,1,0,1};
    bit exp_b2b    [16] = '{1,1,0,0,0,0,1,1, 0,0,0,0,1,1,1,1};
    bit exp_stall_bit [10] = '{1,0,1,1,1,1,0,1,0,0};
    int exp_stall_idx [10] = '{0,1,2,2,2,3,4,5,6,7};

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        if_msb.load_valid = 1'b0; if_msb.data_in = '0; if_msb.shift_en = 1'b1;
        if_lsb.load_valid = 1'b0; if_lsb.data_in = '0; if_lsb.shift_en = 1'b1;

        // ---------------- reset state ----------------
        step(); step();
        check("rst_ser_out",   if_msb.ser_out,    0);
        check("rst_ser_valid", if_msb.ser_valid,  0);
        check("rst_done",      if_msb.done,       0);
        check("rst_bit_idx",   if_msb.bit_idx,    0);
        check("rst_ready",     if_msb.load_ready, 1);
        rst_n = 1'b1;
        step();

        // ---------------- MSB-first word ----------------
        if_msb.data_in = 8'hB4; if_msb.load_valid = 1'b1; if_msb.shift_en = 1'b1;
        #1;
        check("msb_idle_ready", if_msb.load_ready, 1);
        step();
        if_msb.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("msb_bit%0d", i),   if_msb.ser_out,    exp_b4_msb[i]);
            check($sformatf("msb_idx%0d", i),   if_msb.bit_idx,    i);
            check($sformatf("msb_valid%0d", i), if_msb.ser_valid,  1);
            check($sformatf("msb_done%0d", i),  if_msb.done,       (i == 7));
            check($sformatf("msb_ready%0d", i), if_msb.load_ready, (i == 7));
            step();
        end
        check("msb_end_valid", if_msb.ser_valid,  0);
        check("msb_end_done",  if_msb.done,       0);
        check("msb_end_out",   if_msb.ser_out,    0);
        check("msb_end_ready", if_msb.load_ready, 1);

        // ---------------- LSB-first word ----------------
        if_lsb.data_in = 8'hB4; if_lsb.load_valid = 1'b1;
        step();
        if_lsb.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("lsb_bit%0d", i),  if_lsb.ser_out, exp_b4_lsb[i]);
            check($sformatf("lsb_idx%0d", i),  if_lsb.bit_idx, i);
            check($sformatf("lsb_done%0d", i), if_lsb.done,    (i == 7));
            step();
        end
        check("lsb_end_valid", if_lsb.ser_valid, 0);

        // ---------------- back-to-back ----------------
        if_msb.data_in = 8'hC3; if_msb.load_valid = 1'b1;
        step();
        if_msb.data_in = 8'h0F;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("b2b_valid%0d", i), if_msb.ser_valid, 1);
            check($sformatf("b2b_bit%0d", i),   if_msb.ser_out,   exp_b2b[i]);
            check($sformatf("b2b_idx%0d", i),   if_msb.bit_idx,   i % 8);
            if (i < 15)
                check($sformatf("b2b_ready%0d", i), if_msb.load_ready, (i == 7));
            step();
            if (i == 7) if_msb.load_valid = 1'b0;
        end
        check("b2b_end_valid", if_msb.ser_valid, 0);

        // ---------------- stall ----------------
        if_msb.data_in = 8'hB4; if_msb.load_valid = 1'b1;
        step();
        if_msb.load_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("stall_bit%0d", c),   if_msb.ser_out,   exp_stall_bit[c]);
            check($sformatf("stall_idx%0d", c),   if_msb.bit_idx,   exp_stall_idx[c]);
            check($sformatf("stall_valid%0d", c), if_msb.ser_valid, 1);
            check($sformatf("stall_done%0d", c),  if_msb.done,      (c == 9));
            if (c == 2) if_msb.shift_en = 1'b0;
            if (c == 4) if_msb.shift_en = 1'b1;
            if (c < 9) step();
        end
        // Hold on the last bit: ready must stay low while stalled.
        if_msb.shift_en = 1'b0;
        #1;
        check("stall_last_ready_lo", if_msb.load_ready, 0);
        step();
        check("stall_last_done_hold", if_msb.done,       1);
        check("stall_last_bit_hold",  if_msb.ser_out,    0);
        check("stall_last_ready_lo2", if_msb.load_ready, 0);
        if_msb.shift_en = 1'b1;
        #1;
        check("stall_last_ready_hi", if_msb.load_ready, 1);
        step();
        check("stall_end_valid", if_msb.ser_valid, 0);

        // ---------------- ignored load ----------------
        if_msb.data_in = 8'hB4; if_msb.load_valid = 1'b1;
        step();
        if_msb.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ign_bit%0d", i), if_msb.ser_out, exp_b4_msb[i]);
            check($sformatf("ign_idx%0d", i), if_msb.bit_idx, i);
            if (i == 3) begin if_msb.data_in = 8'h55; if_msb.load_valid = 1'b1; end
            if (i == 4) if_msb.load_valid = 1'b0;
            step();
        end
        check("ign_end_valid", if_msb.ser_valid, 0);
        step();
        check("ign_end_valid2", if_msb.ser_valid, 0);

        // ---------------- asynchronous reset mid-word ----------------
        if_msb.data_in = 8'hFF; if_msb.load_valid = 1'b1;
        step();
        if_msb.load_valid = 1'b0;
        step(); step();
        check("arst_pre_idx", if_msb.bit_idx, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ser_out",   if_msb.ser_out,    0);
        check("arst_ser_valid", if_msb.ser_valid,  0);
        check("arst_done",      if_msb.done,       0);
        check("arst_bit_idx",   if_msb.bit_idx,    0);
        check("arst_ready",     if_msb.load_ready, 1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("arst_after_valid%0d", i), if_msb.ser_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
